nucore_pipe: RTL and testbench

//  Parametrised 3-stage pipelined successor of the NuCore datapath: fetch, decode/operand read, execute/writeback.

---
 rtl/nucore_pipe.sv | 186 ++++++++++++++++++
 tb/tb_nucore_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nucore_pipe.sv
// nucore_pipe: three-stage pipelined NuCore datapath.
// Stages: fetch (IF), decode/operand read (ID), execute/writeback (EX).
// Features: generic register file with R0 hard-wired to zero, EX->ID operand bypass,
// zero-flag branch, jump, halt, and a single-step enable that freezes every register.

module nucore_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int PC_W   = 6,
    parameter int IMM_W  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        step_en,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [4+3*REG_AW+IMM_W-1:0] imem_data,
    output logic [DATA_W-1:0]           result,
    output logic                        zero,
    output logic [DATA_W-1:0]           rs_data,
    output logic [DATA_W-1:0]           rt_data,
    output logic                        halted,
    output logic                        retired
);

    localparam int NREGS = 2**REG_AW;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLTU = 4'h6,
        OP_LI   = 4'h7,
        OP_ADDI = 4'h8,
        OP_BZ   = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef struct packed {
        opcode_t           op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    // Architectural and pipeline state
    logic [PC_W-1:0]   pc;
    instr_t            if_id;
    logic              if_id_valid;
    logic              ex_valid;
    opcode_t           ex_op;
    logic [REG_AW-1:0] ex_rd;
    logic [IMM_W-1:0]  ex_imm;
    logic [DATA_W-1:0] regs [NREGS];

    // Combinational control
    logic              advance;
    logic              ex_writes;
    logic              ex_taken;
    logic              ex_halt;
    logic              flush;
    logic              id_halt;
    logic [PC_W-1:0]   ex_target;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign imem_addr = pc;

    // A halted core ignores step_en; only reset releases it.
    assign advance   = step_en && !halted;
    assign ex_writes = ex_valid && (ex_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                                 OP_SLTU, OP_LI, OP_ADDI});
    // zero already reflects every older instruction, since those retired on earlier edges.
    assign ex_taken  = ex_valid && ((ex_op == OP_BZ && zero) || ex_op == OP_JMP);
    assign ex_halt   = ex_valid && (ex_op == OP_HALT);
    assign flush     = ex_taken || ex_halt;
    // A HALT waiting in ID stops fetch so the PC parks just past the HALT word.
    assign id_halt   = if_id_valid && (if_id.op == OP_HALT);
    assign ex_target = ex_imm[PC_W-1:0];
    assign imm_sext  = DATA_W'($signed(ex_imm));

    // EX->ID bypass: an operand being written this cycle is taken from the ALU, not the file.
    // R0 is never written, so reading the file at address 0 always yields zero.
    assign fwd_a = (ex_writes && ex_rd != '0 && ex_rd == if_id.rs) ? alu_val : regs[if_id.rs];
    assign fwd_b = (ex_writes && ex_rd != '0 && ex_rd == if_id.rt) ? alu_val : regs[if_id.rt];

    // ALU: value produced by the instruction currently in EX
    always_comb begin
        // NOTE: default first so every path assigns alu_val and no latch is inferred.
        alu_val = '0;
        case (ex_op)
            OP_ADD:  alu_val = rs_data + rt_data;
            OP_SUB:  alu_val = rs_data - rt_data;
            OP_AND:  alu_val = rs_data & rt_data;
            OP_OR:   alu_val = rs_data | rt_data;
            OP_XOR:  alu_val = rs_data ^ rt_data;
            OP_SLTU: alu_val = DATA_W'(rs_data < rt_data);
            OP_LI:   alu_val = imm_sext;
            OP_ADDI: alu_val = rs_data + imm_sext;
            default: alu_val = '0;
        endcase
    end

    // IF: program counter and fetch register, with redirect, flush and halt parking
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            pc          <= '0;
            if_id       <= '0;
            if_id_valid <= 1'b0;
        end else if (advance) begin
            if (ex_halt) begin
                if_id       <= '0;
                if_id_valid <= 1'b0;
            end else if (ex_taken) begin
                pc          <= ex_target;
                if_id       <= '0;
                if_id_valid <= 1'b0;
            end else if (id_halt) begin
                if_id       <= '0;
                if_id_valid <= 1'b0;
            end else begin
                pc          <= pc + PC_W'(1);
                if_id       <= instr_t'(imem_data);
                if_id_valid <= 1'b1;
            end
        end
    end

    // ID: latch operands (bypassed where needed) and control fields for EX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_op    <= OP_NOP;
            ex_rd    <= '0;
            ex_imm   <= '0;
            rs_data  <= '0;
            rt_data  <= '0;
        end else if (advance) begin
            if (flush) begin
                ex_valid <= 1'b0;
                ex_op    <= OP_NOP;
                ex_rd    <= '0;
                ex_imm   <= '0;
                rs_data  <= '0;
                rt_data  <= '0;
            end else begin
                ex_valid <= if_id_valid;
                ex_op    <= if_id.op;
                ex_rd    <= if_id.rd;
                ex_imm   <= if_id.imm;
                rs_data  <= fwd_a;
                rt_data  <= fwd_b;
            end
        end
    end

    // EX: register file write, result/zero flag, retire pulse and halt latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the file is a small flop array whose all-zero reset state is architecturally visible, so it is reset.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            result  <= '0;
            zero    <= 1'b0;
            halted  <= 1'b0;
            retired <= 1'b0;
        end else begin
            retired <= advance && ex_valid;
            if (advance && ex_valid) begin
                if (ex_writes) begin
                    result <= alu_val;
                    zero   <= (alu_val == '0);
                    if (ex_rd != '0) regs[ex_rd] <= alu_val;
                end
                if (ex_halt) halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nucore_pipe.sv
// tb_nucore_pipe: directed and randomized checks of nucore_pipe against an
// instruction-level reference model kept in the bench.

module tb_nucore_pipe;

    localparam int INSTR_W = 32;

    logic               clock   = 1'b0;
    logic               reset   = 1'b0;
    logic               step_en = 1'b0;
    logic [5:0]         imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [31:0]        result;
    logic               zero;
    logic [31:0]        rs_data;
    logic [31:0]        rt_data;
    logic               halted;
    logic               retired;
    logic [INSTR_W-1:0] imem [64];

    assign imem_data = imem[imem_addr];

    nucore_pipe #(.DATA_W(32), .REG_AW(4), .PC_W(6), .IMM_W(16)) dut (
        .clock(clock), .reset(reset), .step_en(step_en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .result(result), .zero(zero), .rs_data(rs_data), .rt_data(rt_data),
        .halted(halted), .retired(retired)
    );

    // Narrow instance: DATA_W=8, REG_AW=3
    logic        reset8 = 1'b0;
    logic        step8  = 1'b1;
    logic [5:0]  addr8;
    logic [28:0] data8;
    logic [28:0] imem8 [64];
    logic [7:0]  result8, rs8, rt8;
    logic        zero8, halted8, retired8;

    assign data8 = imem8[addr8];

    nucore_pipe #(.DATA_W(8), .REG_AW(3), .PC_W(6), .IMM_W(16)) dut8 (
        .clock(clock), .reset(reset8), .step_en(step8),
        .imem_addr(addr8), .imem_data(data8),
        .result(result8), .zero(zero8), .rs_data(rs8), .rt_data(rt8),
        .halted(halted8), .retired(retired8)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(int op, int rd, int rs, int rt, int imm);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt), 16'(imm)};
    endfunction

    function automatic logic [28:0] enc8(int op, int rd, int rs, int rt, int imm);
        return {4'(op), 3'(rd), 3'(rs), 3'(rt), 16'(imm)};
    endfunction

    // ---------------- Reference model ----------------
    // Architectural registers plus the two in-flight slots. Operands of an instruction
    // are simply the architectural values after every older instruction has executed.
    logic [31:0] m_reg [16];
    logic [5:0]  m_pc;
    logic        m_s1_v, m_s2_v;
    logic [31:0] m_s1, m_s2, m_a, m_b;
    logic [31:0] m_result;
    logic        m_zero, m_halted, m_retired;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_pc = '0; m_s1_v = 0; m_s2_v = 0; m_s1 = '0; m_s2 = '0; m_a = '0; m_b = '0;
        m_result = '0; m_zero = 0; m_halted = 0; m_retired = 0;
    endtask

    task automatic model_step();
        logic [3:0]  op;
        logic [31:0] v, sx;
        logic        redirect, stop;
        logic [5:0]  tgt;
        if (!reset) begin
            model_reset();
            return;
        end
        m_retired = 0;
        if (!step_en || m_halted) return;
        redirect = 0; stop = 0; tgt = '0; v = '0;
        if (m_s2_v) begin
            op = m_s2[31:28];
            sx = {{16{m_s2[15]}}, m_s2[15:0]};
            m_retired = 1;
            if (op >= 4'd1 && op <= 4'd8) begin
                case (op)
                    4'd1: v = m_a + m_b;
                    4'd2: v = m_a - m_b;
                    4'd3: v = m_a & m_b;
                    4'd4: v = m_a | m_b;
                    4'd5: v = m_a ^ m_b;
                    4'd6: v = (m_a < m_b) ? 32'd1 : 32'd0;
                    4'd7: v = sx;
                    default: v = m_a + sx;
                endcase
                m_result = v;
                m_zero   = (v == 0);
                if (m_s2[27:24] != 0) m_reg[m_s2[27:24]] = v;
            end else if ((op == 4'd9 && m_zero) || op == 4'd10) begin
                redirect = 1;
                tgt = m_s2[5:0];
            end else if (op == 4'd15) begin
                stop = 1;
                m_halted = 1;
            end
        end
        if (redirect || stop) begin
            m_s2_v = 0; m_s2 = '0; m_a = '0; m_b = '0; m_s1_v = 0; m_s1 = '0;
            if (redirect) m_pc = tgt;
        end else begin
            m_s2_v = m_s1_v; m_s2 = m_s1;
            m_a = m_reg[m_s1[23:20]];
            m_b = m_reg[m_s1[19:16]];
            if (m_s1_v && m_s1[31:28] == 4'd15) begin
                m_s1_v = 0; m_s1 = '0;
            end else begin
                m_s1 = imem[m_pc]; m_s1_v = 1; m_pc = m_pc + 6'd1;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("pc",      32'(imem_addr), 32'(m_pc));
        check("result",  result,         m_result);
        check("zero",    32'(zero),      32'(m_zero));
        check("rs_data", rs_data,        m_a);
        check("rt_data", rt_data,        m_b);
        check("halted",  32'(halted),    32'(m_halted));
        check("retired", 32'(retired),   32'(m_retired));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step_en = 1'b1;
        model_reset();
        repeat (2) cycle();
        check("rst_addr",    32'(imem_addr), 32'd0);
        check("rst_result",  result,         32'd0);
        check("rst_zero",    32'(zero),      32'd0);
        check("rst_halted",  32'(halted),    32'd0);
        check("rst_retired", 32'(retired),   32'd0);
        reset = 1'b1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = '0;
    endtask

    task automatic load_random();
        for (int i = 0; i < 64; i++) begin
            int r;
            int op;
            r = $urandom_range(0, 99);
            if (r < 60)      op = $urandom_range(1, 8);
            else if (r < 68) op = 9;
            else if (r < 73) op = 10;
            else if (r < 74) op = 15;
            else if (r < 86) op = 0;
            else             op = $urandom_range(11, 14);
            imem[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom));
        end
    endtask

    // Watchdog: the run is bounded by fixed loops; this only guards against a stuck simulator.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          pat [16];
        logic [31:0] exp5 [6];
        logic [31:0] got_q [$];

        clear_imem();
        for (int i = 0; i < 64; i++) imem8[i] = '0;

        // Reset behaviour
        do_reset();

        // Back-to-back bypass
        clear_imem();
        imem[0] = enc(7, 1, 0, 0, 5);
        imem[1] = enc(7, 2, 0, 0, 3);
        imem[2] = enc(1, 3, 1, 2, 0);
        imem[3] = enc(2, 4, 3, 3, 0);
        do_reset();
        cycle(); cycle();
        check("byp_e2_retired", 32'(retired), 32'd0);
        cycle();
        check("byp_e3_result",  result, 32'd5);
        check("byp_e3_retired", 32'(retired), 32'd1);
        cycle();
        check("byp_e4_result",  result, 32'd3);
        cycle();
        check("byp_e5_result",  result, 32'd8);
        check("byp_e5_rs",      rs_data, 32'd8);
        check("byp_e5_rt",      rt_data, 32'd8);
        cycle();
        check("byp_e6_result",  result, 32'd0);
        check("byp_e6_zero",    32'(zero), 32'd1);
        check("byp_e6_retired", 32'(retired), 32'd1);

        // Taken branch and halt
        clear_imem();
        imem[0]  = enc(7, 1, 0, 0, 1);
        imem[1]  = enc(2, 1, 1, 1, 0);
        imem[2]  = enc(9, 0, 0, 0, 10);
        imem[3]  = enc(7, 2, 0, 0, 7);
        imem[4]  = enc(7, 2, 0, 0, 9);
        imem[10] = enc(15, 0, 0, 0, 0);
        do_reset();
        repeat (5) cycle();
        check("br_e5_pc",      32'(imem_addr), 32'd10);
        check("br_e5_retired", 32'(retired), 32'd1);
        cycle();
        check("br_e6_retired", 32'(retired), 32'd0);
        cycle();
        check("br_e7_retired", 32'(retired), 32'd0);
        check("br_e7_halted",  32'(halted), 32'd0);
        cycle();
        check("br_e8_halted",  32'(halted), 32'd1);
        check("br_e8_retired", 32'(retired), 32'd1);
        repeat (3) cycle();
        check("br_end_pc",     32'(imem_addr), 32'd11);
        check("br_end_result", result, 32'd0);
        check("br_end_retired", 32'(retired), 32'd0);

        // Asynchronous reset while frozen by step_en=0
        step_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("areset_pc",     32'(imem_addr), 32'd0);
        check("areset_halted", 32'(halted), 32'd0);
        check("areset_result", result, 32'd0);

        // Not-taken BZ, JMP flush, PC wrap
        clear_imem();
        imem[0]  = enc(8, 1, 0, 0, 16'hFFFF);
        imem[1]  = enc(9, 0, 0, 0, 0);
        imem[2]  = enc(10, 0, 0, 0, 60);
        imem[3]  = enc(7, 3, 0, 0, 16'h33);
        imem[4]  = enc(7, 3, 0, 0, 16'h33);
        imem[63] = enc(7, 6, 0, 0, 6);
        do_reset();
        repeat (3) cycle();
        check("wr_e3_result", result, 32'hFFFF_FFFF);
        check("wr_e3_zero",   32'(zero), 32'd0);
        cycle();
        check("wr_e4_pc",      32'(imem_addr), 32'd4);
        check("wr_e4_retired", 32'(retired), 32'd1);
        cycle();
        check("wr_e5_pc",      32'(imem_addr), 32'd60);
        cycle();
        check("wr_e6_retired", 32'(retired), 32'd0);
        cycle();
        check("wr_e7_retired", 32'(retired), 32'd0);
        cycle();
        check("wr_e8_retired", 32'(retired), 32'd1);
        check("wr_e8_result",  result, 32'hFFFF_FFFF);
        cycle();
        check("wr_e9_pc",      32'(imem_addr), 32'd0);
        repeat (2) cycle();
        check("wr_e11_result", result, 32'd6);

        // step_en toggling in an ADD stream
        clear_imem();
        imem[0] = enc(7, 1, 0, 0, 5);
        imem[1] = enc(7, 2, 0, 0, 3);
        imem[2] = enc(1, 3, 1, 2, 0);
        imem[3] = enc(1, 4, 3, 1, 0);
        imem[4] = enc(1, 5, 4, 3, 0);
        imem[5] = enc(1, 6, 5, 5, 0);
        exp5 = '{32'd5, 32'd3, 32'd8, 32'd13, 32'd21, 32'd42};
        pat  = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
        do_reset();
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            step_en = pat[i][0];
            cycle();
            if (retired) got_q.push_back(result);
            if (pat[i] == 0) check("step_hold_retired", 32'(retired), 32'd0);
        end
        step_en = 1'b1;
        check("step_nret", 32'(got_q.size()), 32'd9);
        for (int k = 0; k < 6; k++)
            if (k < got_q.size()) check("step_result", got_q[k], exp5[k]);

        // Randomized programs with random step_en and occasional reset
        for (int p = 0; p < 12; p++) begin
            load_random();
            do_reset();
            for (int c = 0; c < 250; c++) begin
                step_en = ($urandom_range(0, 99) < 85);
                reset   = ($urandom_range(0, 299) != 0);
                cycle();
                reset   = 1'b1;
            end
        end

        // Narrow-parameter instance
        imem8[0] = enc8(7, 1, 0, 0, 200);
        imem8[1] = enc8(7, 2, 0, 0, 100);
        imem8[2] = enc8(1, 3, 1, 2, 0);
        imem8[3] = enc8(7, 0, 0, 0, 5);
        imem8[4] = enc8(1, 4, 0, 0, 0);
        imem8[5] = enc8(15, 0, 0, 0, 0);
        @(negedge clock);
        check("n8_rst_result", 32'(result8), 32'd0);
        reset8 = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            @(negedge clock);
            case (e)
                3: check("n8_e3_result", 32'(result8), 32'd200);
                4: check("n8_e4_result", 32'(result8), 32'd100);
                5: begin
                    check("n8_e5_result", 32'(result8), 32'd44);
                    check("n8_e5_zero",   32'(zero8),   32'd0);
                end
                7: begin
                    check("n8_e7_result", 32'(result8), 32'd0);
                    check("n8_e7_zero",   32'(zero8),   32'd1);
                end
                8: check("n8_e8_halted", 32'(halted8), 32'd1);
                9: check("n8_e9_pc",     32'(addr8),   32'd6);
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
